data_mem_lsu: RTL and testbench
===============================

DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words; power of two, at least 16.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0; aligned to DEPTH_WORDS*4.
REQ-003 Parameter INIT_FILE, default "", meaning hex image loaded at elaboration; empty means no load.
REQ-004 Port clk, input, 1, meaning the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1, meaning asynchronous, active-low reset.
REQ-006 Port req_valid, input, 1, meaning a request is presented.
REQ-007 Port req_ready, output, 1, meaning the block accepts a request this cycle.
REQ-008 Port req_write, input, 1, meaning 1 for a store, 0 for a load.
REQ-009 Port req_funct3, input, 3, meaning the RV32 access type: LB/LH/LW/LBU/LHU, or SB/SH/SW.
REQ-010 Port req_addr, input, 32, meaning byte address.
REQ-011 Port req_wdata, input, 32, meaning store data, right-aligned.
REQ-012 Port resp_valid, output, 1, meaning a response is held.
REQ-013 Port resp_ready, input, 1, meaning the consumer takes the response.
REQ-014 Port resp_rdata, output, 32, meaning the extended load data; 0 for stores and faults.
REQ-015 Port resp_fault, output, 2, meaning lsu_pkg status: OK=0, MISALIGNED=1, OUT_OF_RANGE=2, BAD_FUNCT3=3.

Function
REQ-016 A request shall be accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-017 The FSM shall have two states:
- IDLE: req_ready=1.
- RESP: resp_valid=1, and req_ready=resp_ready.
REQ-018 FSM transitions:
- IDLE to RESP on acceptance.
- RESP to IDLE on resp_ready with no new acceptance.
- RESP stays in RESP when resp_ready and a new request are accepted in the same cycle (back-to-back, one response per cycle).
REQ-019 The response shall appear exactly 1 cycle after acceptance.
REQ-020 resp_rdata and resp_fault shall be registered and shall stay stable while resp_valid=1 and resp_ready=0.
REQ-021 Memory read shall be synchronous: the word is read at the acceptance edge, and byte/half selection plus extension are applied to the registered word.
REQ-022 Load extraction: lane = addr[1:0] for bytes and addr[1] for halves. LB/LH sign-extend; LBU/LHU zero-extend; LW returns the whole word.
REQ-023 Stores shall write at the acceptance edge using byte enables:
- SB: one lane, wdata[7:0].
- SH: two lanes, wdata[15:0].
- SW: all four lanes.
- Unwritten lanes are preserved.
REQ-024 Fault checks:
- MISALIGNED: addr[0]!=0 for a half, or addr[1:0]!=0 for a word.
- OUT_OF_RANGE: addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
- BAD_FUNCT3: a load funct3 of 3, 6 or 7, or a store funct3 above 2.
REQ-025 Fault priority shall be BAD_FUNCT3, then MISALIGNED, then OUT_OF_RANGE.
REQ-026 A faulting store shall not modify memory, and any faulting access shall return resp_rdata=0.
REQ-027 The word index shall be (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]. No wrap-around: the topmost word is valid, and the next address is OUT_OF_RANGE.
REQ-028 A load accepted in the cycle after a store to the same word shall return the stored data (ordering is guaranteed by one access per edge).

Reset
REQ-029 While rst_n=0:
- state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=OK.
- req_ready=0 during reset, and 1 from the first edge after deassertion.
REQ-030 Reset asserted while in RESP shall drop the pending response, and no response shall be issued for it.
REQ-031 Memory contents shall not be reset, and no write shall occur at an edge where rst_n=0.

Structure
REQ-032 Package lsu_pkg shall hold:
- the funct3 encodings as an enum;
- the fault status enum;
- the byte-enable width constant.
REQ-033 One combinational sub-module, lsu_align, shall compute the byte enables and shifted write data for stores, and the lane extract/extension for loads.
REQ-034 The memory array shall be inferable as block RAM: one synchronous read port, one byte-enabled write port.

Verification
REQ-035 SW 0xDEADBEEF at 0x10, then LW 0x10 -> resp_rdata=0xDEADBEEF, fault=OK, exactly 1 cycle after acceptance.
REQ-036 SB 0x80 at 0x13 into word 0x11223344, then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080, and LW 0x10 -> 0x80223344.
REQ-037 SH at 0x11 -> MISALIGNED, with memory unchanged. Load funct3=3 -> BAD_FUNCT3. LW at BASE_ADDR+4*DEPTH_WORDS -> OUT_OF_RANGE with rdata=0.
REQ-038 resp_ready held 0 for 3 cycles -> resp stable and req_ready=0. Then resp_ready=1 with req_valid=1 -> back-to-back acceptance, one response per cycle.
REQ-039 rst_n pulsed low while in RESP -> resp_valid falls immediately, and no stale response follows. A store presented during reset leaves memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
package lsu_pkg;

    // RV32 load/store funct3 codes; stores reuse the B/H/W codes.
    typedef enum logic [2:0] {
        F3_B  = 3'd0,
        F3_H  = 3'd1,
        F3_W  = 3'd2,
        F3_BU = 3'd4,
        F3_HU = 3'd5
    } funct3_e;

    // Response status reported alongside every response.
    typedef enum logic [1:0] {
        FAULT_OK           = 2'd0,
        FAULT_MISALIGNED   = 2'd1,
        FAULT_OUT_OF_RANGE = 2'd2,
        FAULT_BAD_FUNCT3   = 2'd3
    } fault_e;

    // Byte lanes per 32-bit word.
    localparam int unsigned BE_W = 4;

    // Access size, taken from funct3[1:0].
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables and replicated write data for stores,
// lane extraction and sign/zero extension for loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      st_size,
    input  logic [1:0]      st_lane,
    input  logic [31:0]     st_wdata,
    output logic [BE_W-1:0] st_be,
    output logic [31:0]     st_data,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_lane,
    input  logic [31:0]     ld_word,
    output logic [31:0]     ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // One enable per lane: whole word, the addressed half, or the addressed byte.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_be
            localparam logic [1:0] LANE = 2'(gi);
            assign st_be[gi] = (st_size == SZ_W)
                             | ((st_size == SZ_H) && (st_lane[1] == LANE[1]))
                             | ((st_size == SZ_B) && (st_lane == LANE));
        end
    endgenerate

    // Replicate store data across lanes; the enables pick the live ones.
    always_comb begin
        case (st_size)
            SZ_B:    st_data = {4{st_wdata[7:0]}};
            SZ_H:    st_data = {2{st_wdata[15:0]}};
            default: st_data = st_wdata;
        endcase
    end

    assign ld_byte = ld_word[{ld_lane, 3'b000} +: 8];
    assign ld_half = ld_word[{ld_lane[1], 4'b0000} +: 16];

    // Extend the selected lane according to the load type.
    always_comb begin
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_W:    ld_data = ld_word;
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Single-port data memory with an RV32 load/store front end and a
// one-entry valid/ready response stage.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_fault
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

    typedef enum logic {ST_IDLE, ST_RESP} state_e;

    state_e          state_reg;
    logic            ready_en_reg;
    fault_e          fault_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      lane_reg;
    logic            load_reg;
    logic [31:0]     rd_word_reg;

    logic [31:0]     offset;
    logic [AW-1:0]   word_idx;
    logic            in_range;
    logic            bad_funct3;
    logic            misaligned;
    fault_e          fault_next;
    logic            accept;
    logic            wr_en;
    logic [BE_W-1:0] st_be;
    logic [31:0]     st_data;
    logic [31:0]     ld_data;

    logic [31:0]     mem [DEPTH_WORDS];

    // Addresses below the base wrap to a huge offset, so one unsigned compare covers both ends.
    assign offset   = req_addr - BASE_ADDR;
    assign word_idx = offset[AW+1:2];
    assign in_range = (offset < SPAN);

    assign bad_funct3 = req_write ? (req_funct3 > 3'd2)
                                  : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
    assign misaligned = ((req_funct3[1:0] == SZ_H) && req_addr[0])
                      || ((req_funct3[1:0] == SZ_W) && (req_addr[1:0] != 2'b00));

    // Fault classification in priority order.
    always_comb begin
        fault_next = FAULT_OK;
        if (bad_funct3) begin
            fault_next = FAULT_BAD_FUNCT3;
        end else if (misaligned) begin
            fault_next = FAULT_MISALIGNED;
        end else if (!in_range) begin
            fault_next = FAULT_OUT_OF_RANGE;
        end
    end

    // ready_en_reg is cleared asynchronously, so no access can start while rst_n is low.
    assign req_ready = ready_en_reg && ((state_reg == ST_IDLE) || resp_ready);
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_write && (fault_next == FAULT_OK) && rst_n;

    lsu_align u_align (
        .st_size   (req_funct3[1:0]),
        .st_lane   (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_be     (st_be),
        .st_data   (st_data),
        .ld_funct3 (funct3_reg),
        .ld_lane   (lane_reg),
        .ld_word   (rd_word_reg),
        .ld_data   (ld_data)
    );

    // Block RAM: byte-enabled write and registered read, both at the acceptance edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (st_be[b]) begin
                    mem[word_idx][b*8 +: 8] <= st_data[b*8 +: 8];
                end
            end
        end
        if (accept) begin
            rd_word_reg <= mem[word_idx];
        end
    end

    // Response FSM: capture request attributes on acceptance, release on resp_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ready_en_reg <= 1'b0;
            fault_reg    <= FAULT_OK;
            funct3_reg   <= 3'd0;
            lane_reg     <= 2'd0;
            load_reg     <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (accept) begin
                state_reg  <= ST_RESP;
                fault_reg  <= fault_next;
                funct3_reg <= req_funct3;
                lane_reg   <= req_addr[1:0];
                load_reg   <= !req_write;
            end else if ((state_reg == ST_RESP) && resp_ready) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    assign resp_valid = (state_reg == ST_RESP);
    assign resp_fault = fault_reg;
    assign resp_rdata = (resp_valid && load_reg && (fault_reg == FAULT_OK)) ? ld_data : 32'd0;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu: directed vector table, handshake
// corner sequences and randomized traffic against a byte-array model.
module tb_data_mem_lsu;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam int          SPAN  = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_fault;

    int total = 0;
    int bad   = 0;

    byte unsigned mb [SPAN];

    typedef struct {
        bit          w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [1:0]  exp_f;
        string       name;
    } vec_t;

    vec_t vt [$];

    data_mem_lsu #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE),
        .INIT_FILE   ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Reference: treats memory as a flat byte array and applies the access rules directly.
    function automatic void model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] flt);
        longint off;
        longint v;
        int     sz;
        bit     bad_f3;
        off    = longint'(a) - longint'(BASE);
        bad_f3 = w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        sz     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        rd     = 32'd0;
        if (bad_f3)                      flt = 2'd3;
        else if ((a % sz) != 0)          flt = 2'd1;
        else if (off < 0 || off >= SPAN) flt = 2'd2;
        else begin
            flt = 2'd0;
            if (w) begin
                for (int i = 0; i < sz; i++) mb[int'(off) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < sz; i++) v += longint'(mb[int'(off) + i]) << (8 * i);
                if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                    v -= longint'(1) << (8 * sz);
                rd = v[31:0];
            end
        end
    endfunction

    // One request/response; checks 1-cycle latency and stability while stalled.
    task automatic xact(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int stall, output logic [31:0] rd, output logic [1:0] flt);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        resp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid  = 1'b0;
            resp_ready = 1'b1;
            rd  = 32'd0;
            flt = 2'd0;
            return;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("resp_latency", 32'(resp_valid), 32'd1);
        rd  = resp_rdata;
        flt = resp_fault;
        for (int i = 1; i < stall; i++) begin
            @(negedge clk);
            check("stall_hold", {resp_valid, req_ready, resp_fault, 28'd0} ^ {1'b0, 1'b0, flt, 28'd0},
                  {1'b1, 1'b0, 30'd0});
            check("stall_rdata", resp_rdata, rd);
        end
        resp_ready = 1'b1;
    endtask

    task automatic add(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic [1:0] ef, input string nm);
        vec_t v;
        v.w = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rd = er; v.exp_f = ef; v.name = nm;
        vt.push_back(v);
    endtask

    initial begin
        logic [31:0] rd, mrd, e1, e2, e3;
        logic [1:0]  flt, mflt;
        bit          w;
        logic [2:0]  f3;
        logic [31:0] a, wd;
        int          r, sz, stall, n;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;

        // Reset state
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_req_ready",  32'(req_ready),  32'd0);
        check("rst_rdata",      resp_rdata,      32'd0);
        check("rst_fault",      32'(resp_fault), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 check("ready_after_edge", 32'(req_ready), 32'd1);

        // Fill every word so later loads have defined contents
        for (int i = 0; i < DEPTH; i++) begin
            wd = $urandom;
            a  = BASE + 32'(4 * i);
            xact(1'b1, 3'd2, a, wd, 0, rd, flt);
            model(1'b1, 3'd2, a, wd, mrd, mflt);
            check("fill_fault", 32'(flt), 32'(mflt));
        end

        // Directed vectors
        add(1, 3'd2, BASE + 32'h10, 32'hDEADBEEF, 32'h0,        2'd0, "sw_deadbeef");
        add(0, 3'd2, BASE + 32'h10, 32'h0,        32'hDEADBEEF, 2'd0, "lw_deadbeef");
        add(1, 3'd2, BASE + 32'h10, 32'h11223344, 32'h0,        2'd0, "sw_11223344");
        add(1, 3'd0, BASE + 32'h13, 32'hFFFFFF80, 32'h0,        2'd0, "sb_80");
        add(0, 3'd0, BASE + 32'h13, 32'h0,        32'hFFFFFF80, 2'd0, "lb_13");
        add(0, 3'd4, BASE + 32'h13, 32'h0,        32'h00000080, 2'd0, "lbu_13");
        add(0, 3'd2, BASE + 32'h10, 32'h0,        32'h80223344, 2'd0, "lw_after_sb");
        add(1, 3'd1, BASE + 32'h11, 32'h0000BBAA, 32'h0,        2'd1, "sh_misaligned");
        add(0, 3'd2, BASE + 32'h10, 32'h0,        32'h80223344, 2'd0, "lw_unchanged");
        add(0, 3'd3, BASE + 32'h10, 32'h0,        32'h0,        2'd3, "load_f3_3");
        add(0, 3'd2, BASE + SPAN,   32'h0,        32'h0,        2'd2, "lw_past_top");
        add(1, 3'd2, BASE + SPAN - 4, 32'hCAFEF00D, 32'h0,      2'd0, "sw_top");
        add(0, 3'd2, BASE + SPAN - 4, 32'h0,      32'hCAFEF00D, 2'd0, "lw_top");
        add(0, 3'd2, BASE - 4,      32'h0,        32'h0,        2'd2, "lw_below_base");
        add(0, 3'd1, BASE + 32'h12, 32'h0,        32'hFFFF8022, 2'd0, "lh_12");
        add(0, 3'd5, BASE + 32'h12, 32'h0,        32'h00008022, 2'd0, "lhu_12");
        add(1, 3'd5, BASE + 32'h11, 32'h0,        32'h0,        2'd3, "store_f3_5_prio");
        add(0, 3'd1, BASE + SPAN + 1, 32'h0,      32'h0,        2'd1, "lh_mis_over_oor");
        add(0, 3'd7, BASE + SPAN + 3, 32'h0,      32'h0,        2'd3, "load_f3_7_prio");
        add(1, 3'd3, BASE + 32'h10, 32'h0,        32'h0,        2'd3, "store_f3_3");
        add(1, 3'd1, BASE + 32'h12, 32'h1234BBAA, 32'h0,        2'd0, "sh_12");
        add(0, 3'd2, BASE + 32'h10, 32'h0,        32'hBBAA3344, 2'd0, "lw_after_sh");
        add(0, 3'd0, BASE + 32'h10, 32'h0,        32'h00000044, 2'd0, "lb_10");
        add(0, 3'd0, BASE + 32'h11, 32'h0,        32'h00000033, 2'd0, "lb_11");
        add(0, 3'd1, BASE + 32'h10, 32'h0,        32'h00003344, 2'd0, "lh_10");
        add(0, 3'd2, BASE + 32'h12, 32'h0,        32'h0,        2'd1, "lw_misaligned");
        foreach (vt[i]) begin
            xact(vt[i].w, vt[i].f3, vt[i].addr, vt[i].wdata, 0, rd, flt);
            model(vt[i].w, vt[i].f3, vt[i].addr, vt[i].wdata, mrd, mflt);
            $display("vec %s: rdata=%h fault=%0d", vt[i].name, rd, flt);
            check({vt[i].name, "_rdata"}, rd, vt[i].exp_rd);
            check({vt[i].name, "_fault"}, 32'(flt), 32'(vt[i].exp_f));
        end

        // Backpressure for three cycles, then back-to-back acceptances
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = BASE + 32'h10;
        @(posedge clk);
        #1;
        model(1'b0, 3'd2, BASE + 32'h10, 32'h0, e1, mflt);
        req_funct3 = 3'd4; req_addr = BASE + 32'h13;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_rdata", resp_rdata, e1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        $display("xact backpressure lw rdata=%h", resp_rdata);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        model(1'b0, 3'd4, BASE + 32'h13, 32'h0, e2, mflt);
        req_funct3 = 3'd2; req_addr = BASE + SPAN - 4;
        @(negedge clk);
        check("b2b_valid1", 32'(resp_valid), 32'd1);
        check("b2b_rdata1", resp_rdata, e2);
        check("b2b_ready1", 32'(req_ready), 32'd1);
        $display("xact back-to-back lbu rdata=%h", resp_rdata);
        @(posedge clk);
        #1 req_valid = 1'b0;
        model(1'b0, 3'd2, BASE + SPAN - 4, 32'h0, e3, mflt);
        @(negedge clk);
        check("b2b_valid2", 32'(resp_valid), 32'd1);
        check("b2b_rdata2", resp_rdata, e3);
        $display("xact back-to-back lw rdata=%h", resp_rdata);
        @(negedge clk);
        check("b2b_drain", 32'(resp_valid), 32'd0);

        // Reset while a response is pending; store presented during reset
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = BASE + 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(resp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_drop_valid", 32'(resp_valid), 32'd0);
        check("rst_drop_ready", 32'(req_ready),  32'd0);
        check("rst_drop_rdata", resp_rdata,      32'd0);
        check("rst_drop_fault", 32'(resp_fault), 32'd0);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = BASE + 32'h10; req_wdata = 32'h55555555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        check("no_stale_resp", 32'(n), 32'd0);
        $display("xact reset during response: stale responses=%0d", n);
        xact(1'b0, 3'd2, BASE + 32'h10, 32'h0, 0, rd, flt);
        model(1'b0, 3'd2, BASE + 32'h10, 32'h0, mrd, mflt);
        check("rst_store_blocked", rd, mrd);
        $display("xact lw after reset store rdata=%h", rd);

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            w = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r == 0) f3 = 3'($urandom_range(0, 7));
            else if (w) f3 = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE + SPAN + 32'($urandom_range(0, 15));
            else if (r == 1) a = BASE - 32'd1 - 32'($urandom_range(0, 15));
            else             a = BASE + 32'($urandom_range(0, SPAN - 1));
            if (r >= 3) a = a & ~32'(sz - 1);
            wd    = $urandom;
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            xact(w, f3, a, wd, stall, rd, flt);
            model(w, f3, a, wd, mrd, mflt);
            $display("xact rnd w=%0d f3=%0d addr=%h wdata=%h stall=%0d -> rdata=%h fault=%0d",
                     w, f3, a, wd, stall, rd, flt);
            check("rnd_rdata", rd, mrd);
            check("rnd_fault", 32'(flt), 32'(mflt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
